// File: rtl/amiga_wcs_cycle_ctl.sv
// Bus-cycle controller for the WCS daughterboard: decodes 68000 cycles into RAM/ROM
// strobes, DTACK/BERR and a one-shot write-protect lock.
module amiga_wcs_cycle_ctl #(
    parameter int unsigned WAIT = 2
) (
    input  logic C7M,
    input  logic RES,
    input  logic _AS,
    input  logic _UDS,
    input  logic _LDS,
    input  logic _PRW,
    input  logic A18,
    input  logic A17,
    input  logic _RE,
    input  logic _SROM,
    output logic _UCEN,
    output logic _LCEN,
    output logic _CDR,
    output logic _CDW,
    output logic _RRW,
    output logic _ROM01,
    output logic _DTACK,
    output logic _BERR,
    output logic _WPRO
);

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_STROBE,
        S_ACK,
        S_FAULT
    } state_t;

    typedef enum logic [1:0] {
        C_RAMRD,
        C_ROMRD,
        C_RAMWR,
        C_LOCK
    } cls_t;

    state_t     state_q, state_d;
    cls_t       cls_q, cls_d, cls_c;
    logic       uds_q, uds_d, lds_q, lds_d;
    logic [3:0] cnt_q, cnt_d;
    logic       wpro_q, wpro_d;
    logic       fault_c;
    logic       ucen_d, lcen_d, cdr_d, cdw_d, rrw_d, rom_d, dtack_d, berr_d;

    // Cycle classification from the live inputs; only consumed while in DECODE.
    always_comb begin
        cls_c   = C_RAMRD;
        fault_c = 1'b0;
        if (_PRW) begin
            if (A18 || wpro_q || !_SROM) cls_c = C_RAMRD;
            else if (!A17)               cls_c = C_ROMRD;
            else                         fault_c = 1'b1;
        end else begin
            if (wpro_q)   fault_c = 1'b1;
            else if (A18) cls_c = C_RAMWR;
            else          cls_c = C_LOCK;
        end
    end

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        uds_d   = uds_q;
        lds_d   = lds_q;
        cnt_d   = cnt_q;
        wpro_d  = wpro_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = 4'd0;
                if (!_AS && !_RE && (!_UDS || !_LDS)) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (_AS) begin
                    state_d = S_IDLE;
                end else begin
                    cls_d = cls_c;
                    uds_d = _UDS;
                    lds_d = _LDS;
                    if (fault_c) begin
                        state_d = S_FAULT;
                    end else begin
                        state_d = S_STROBE;
                        cnt_d   = WAIT_CNT;
                    end
                end
            end
            S_STROBE: begin
                if (_AS) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                if (_AS) begin
                    state_d = S_IDLE;
                    if (cls_q == C_LOCK) wpro_d = 1'b1;
                end
            end
            S_FAULT: begin
                if (_AS) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every pin comes straight off a flop.
    always_comb begin
        ucen_d  = 1'b1;
        lcen_d  = 1'b1;
        cdr_d   = 1'b1;
        cdw_d   = 1'b1;
        rrw_d   = 1'b1;
        rom_d   = 1'b1;
        dtack_d = 1'b1;
        berr_d  = 1'b1;
        if (state_d == S_STROBE || state_d == S_ACK) begin
            case (cls_d)
                C_RAMRD: begin
                    ucen_d = uds_d;
                    lcen_d = lds_d;
                    cdr_d  = 1'b0;
                end
                C_ROMRD: begin
                    rom_d = 1'b0;
                    cdr_d = 1'b0;
                end
                C_RAMWR: begin
                    ucen_d = uds_d;
                    lcen_d = lds_d;
                    cdw_d  = 1'b0;
                    rrw_d  = 1'b0;
                end
                default: ;
            endcase
            if (state_d == S_ACK) dtack_d = 1'b0;
        end
        if (state_d == S_FAULT) berr_d = 1'b0;
    end

    always_ff @(posedge C7M or posedge RES) begin
        if (RES) begin
            state_q <= S_IDLE;
            cls_q   <= C_RAMRD;
            uds_q   <= 1'b1;
            lds_q   <= 1'b1;
            cnt_q   <= 4'd0;
            wpro_q  <= 1'b0;
            _UCEN   <= 1'b1;
            _LCEN   <= 1'b1;
            _CDR    <= 1'b1;
            _CDW    <= 1'b1;
            _RRW    <= 1'b1;
            _ROM01  <= 1'b1;
            _DTACK  <= 1'b1;
            _BERR   <= 1'b1;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            uds_q   <= uds_d;
            lds_q   <= lds_d;
            cnt_q   <= cnt_d;
            wpro_q  <= wpro_d;
            _UCEN   <= ucen_d;
            _LCEN   <= lcen_d;
            _CDR    <= cdr_d;
            _CDW    <= cdw_d;
            _RRW    <= rrw_d;
            _ROM01  <= rom_d;
            _DTACK  <= dtack_d;
            _BERR   <= berr_d;
        end
    end

    assign _WPRO = ~wpro_q;

endmodule

// File: tb/tb_amiga_wcs_cycle_ctl.sv
// Directed bench for amiga_wcs_cycle_ctl; expected pin vectors are queued per edge
// and popped as the clock advances.
module tb_amiga_wcs_cycle_ctl;

    localparam int WAIT = 2;

    logic C7M = 1'b0;
    logic RES, _AS, _UDS, _LDS, _PRW, A18, A17, _RE, _SROM;
    logic _UCEN, _LCEN, _CDR, _CDW, _RRW, _ROM01, _DTACK, _BERR, _WPRO;

    int total = 0;
    int bad = 0;
    logic wpro_m = 1'b0;
    logic [8:0] exp_q[$];

    amiga_wcs_cycle_ctl #(.WAIT(WAIT)) dut (
        .C7M(C7M), .RES(RES), ._AS(_AS), ._UDS(_UDS), ._LDS(_LDS), ._PRW(_PRW),
        .A18(A18), .A17(A17), ._RE(_RE), ._SROM(_SROM),
        ._UCEN(_UCEN), ._LCEN(_LCEN), ._CDR(_CDR), ._CDW(_CDW), ._RRW(_RRW),
        ._ROM01(_ROM01), ._DTACK(_DTACK), ._BERR(_BERR), ._WPRO(_WPRO)
    );

    always #5 C7M = ~C7M;

    // {_UCEN,_LCEN,_CDR,_CDW,_RRW,_ROM01,_DTACK,_BERR,_WPRO}
    function automatic logic [8:0] outs();
        return {_UCEN, _LCEN, _CDR, _CDW, _RRW, _ROM01, _DTACK, _BERR, _WPRO};
    endfunction

    function automatic logic [8:0] idle_v();
        return {8'hFF, ~wpro_m};
    endfunction

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick(input string tag);
        logic [8:0] e;
        @(posedge C7M);
        #1;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s observed=queue_empty expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, outs(), e);
        end
    endtask

    task automatic drive_start(input logic prw, a18, a17, srom_n, uds_n, lds_n);
        _AS = 1'b0; _RE = 1'b0; _PRW = prw; A18 = a18; A17 = a17;
        _SROM = srom_n; _UDS = uds_n; _LDS = lds_n;
    endtask

    task automatic bus_cycle(input string tag, input logic prw, a18, a17, srom_n,
                             uds_n, lds_n, input int ack_hold);
        logic [7:0] sv;
        bit is_fault, is_lock, ramrd, romrd, ramwr;
        int n;
        ramrd = 0; romrd = 0; ramwr = 0; is_fault = 0; is_lock = 0;
        if (prw) begin
            if (a18 || wpro_m || !srom_n) ramrd = 1;
            else if (!a17)                romrd = 1;
            else                          is_fault = 1;
        end else begin
            if (wpro_m)   is_fault = 1;
            else if (a18) ramwr = 1;
            else          is_lock = 1;
        end
        sv = {(ramrd || ramwr) ? uds_n : 1'b1, (ramrd || ramwr) ? lds_n : 1'b1,
              !(ramrd || romrd), !ramwr, !ramwr, !romrd, 1'b1, 1'b1};
        exp_q.push_back(idle_v());
        if (is_fault) begin
            n = 2 + ack_hold;
            repeat (1 + ack_hold) exp_q.push_back({8'b1111_1110, ~wpro_m});
        end else begin
            n = 1 + (WAIT + 1) + 1 + ack_hold;
            repeat (WAIT + 1) exp_q.push_back({sv, ~wpro_m});
            repeat (1 + ack_hold) exp_q.push_back({sv[7:2], 1'b0, 1'b1, ~wpro_m});
        end
        drive_start(prw, a18, a17, srom_n, uds_n, lds_n);
        for (int i = 0; i < n; i++) begin
            tick(tag);
            if (i == 1) begin
                _UDS = ~uds_n;
                _LDS = ~lds_n;
            end
        end
        _AS = 1'b1; _UDS = 1'b1; _LDS = 1'b1;
        if (is_lock) wpro_m = 1'b1;
        exp_q.push_back(idle_v());
        tick({tag, "_end"});
        exp_q.push_back(idle_v());
        tick({tag, "_gap"});
    endtask

    initial begin
        RES = 1'b1; _AS = 1'b1; _UDS = 1'b1; _LDS = 1'b1; _PRW = 1'b1;
        A18 = 1'b0; A17 = 1'b0; _RE = 1'b1; _SROM = 1'b1;
        #1;
        chk("reset_outputs", outs(), 9'h1FF);
        #11;
        RES = 1'b0;
        exp_q.push_back(idle_v());
        tick("post_reset_idle");

        bus_cycle("ram_read", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        bus_cycle("rom_read", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        bus_cycle("byte_write", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        bus_cycle("upper_read", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0);
        bus_cycle("srom_read", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        bus_cycle("read_fault", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1);

        // abort during STROBE
        exp_q.push_back(idle_v());
        exp_q.push_back({8'b0001_1111, ~wpro_m});
        drive_start(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick("abort_decode");
        tick("abort_strobe");
        _AS = 1'b1; _UDS = 1'b1; _LDS = 1'b1;
        exp_q.push_back(idle_v());
        tick("abort_idle");
        exp_q.push_back(idle_v());
        tick("abort_gap");

        bus_cycle("lock_write", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        chk("wpro_after_lock", {8'h00, _WPRO}, 9'h000);
        bus_cycle("retry_write", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        bus_cycle("shadow_read", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);

        // reset pulse while in ACK
        exp_q.push_back(idle_v());
        repeat (WAIT + 1) exp_q.push_back({8'b0001_1111, ~wpro_m});
        exp_q.push_back({8'b0001_1101, ~wpro_m});
        drive_start(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (WAIT + 3) tick("res_cycle");
        #2;
        RES = 1'b1;
        #1;
        wpro_m = 1'b0;
        chk("res_async", outs(), 9'h1FF);
        _AS = 1'b1; _UDS = 1'b1; _LDS = 1'b1;
        @(posedge C7M);
        #1;
        chk("res_held", outs(), 9'h1FF);
        RES = 1'b0;
        exp_q.push_back(idle_v());
        tick("res_release_idle");

        bus_cycle("write_after_res", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0);

        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
